// File: rtl/guess_input_conditioner.sv
// Input conditioner for the guessing game: synchronizes the raw key and switches, debounces the key,
// and emits one oBtn pulse per accepted press together with a switch snapshot and a press count.
module guess_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iKey_n,
  input  logic [9:0] iSwitch,
  output logic       oBtn,
  output logic [9:0] oSwitch,
  output logic       oBusy,
  output logic [7:0] oPressCnt
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    FIRE,
    HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_meta_q, key_s_q;
  logic [9:0]       sw_meta_q, sw_s_q;
  logic [9:0]       sw_cap_q;
  logic [7:0]       press_cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!key_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        state_d = HELD;
      end
      HELD: begin
        if (key_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_meta_q  <= 1'b1;
      key_s_q     <= 1'b1;
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      sw_cap_q    <= '0;
      press_cnt_q <= '0;
    end else begin
      key_meta_q <= iKey_n;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= iSwitch;
      sw_s_q     <= sw_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // Snapshot and count on the edge that enters FIRE so they are valid alongside oBtn.
      if (state_d == FIRE) begin
        sw_cap_q    <= sw_s_q;
        press_cnt_q <= press_cnt_q + 8'd1;
      end
    end
  end

  assign oBtn      = (state_q == FIRE);
  assign oBusy     = (state_q != IDLE);
  assign oSwitch   = sw_cap_q;
  assign oPressCnt = press_cnt_q;

endmodule

// File: tb/tb_guess_input_conditioner.sv
// Bench for guess_input_conditioner: run-length reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key/switch/reset activity.
module tb_guess_input_conditioner;
  localparam int D = 4;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iKey_n = 1'b1;
  logic [9:0] iSwitch = '0;
  logic       oBtn, oBusy;
  logic [9:0] oSwitch;
  logic [7:0] oPressCnt;

  guess_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iKey_n(iKey_n), .iSwitch(iSwitch),
    .oBtn(oBtn), .oSwitch(oSwitch), .oBusy(oBusy), .oPressCnt(oPressCnt)
  );

  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the key the block sees is the raw key two edges old. Armed, it needs D+1
  // consecutive low samples to fire; after the fire cycle it needs D+1 consecutive high
  // samples before re-arming. Any opposite sample restarts the run.
  logic       m_k1, m_k2;
  logic [9:0] m_s1, m_s2;
  int         m_mode;  // 0 armed, 1 firing, 2 waiting for release
  int         m_run;
  logic       m_btn;
  logic [9:0] m_sw;
  logic [7:0] m_cnt;
  logic       m_busy;
  assign m_busy = (m_mode != 0) || (m_run != 0);

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      m_k1 <= 1'b1; m_k2 <= 1'b1; m_s1 <= '0; m_s2 <= '0;
      m_mode <= 0; m_run <= 0; m_btn <= 1'b0; m_sw <= '0; m_cnt <= '0;
    end else begin
      m_k1 <= iKey_n; m_k2 <= m_k1;
      m_s1 <= iSwitch; m_s2 <= m_s1;
      m_btn <= 1'b0;
      case (m_mode)
        0: begin
          if (m_k2) m_run <= 0;
          else if (m_run == D) begin
            m_mode <= 1; m_run <= 0; m_btn <= 1'b1; m_sw <= m_s2; m_cnt <= m_cnt + 8'd1;
          end else m_run <= m_run + 1;
        end
        1: begin
          m_mode <= 2; m_run <= 0;
        end
        default: begin
          if (!m_k2) m_run <= 0;
          else if (m_run == D) begin
            m_mode <= 0; m_run <= 0;
          end else m_run <= m_run + 1;
        end
      endcase
    end
  end

  bit chk_en = 1'b0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = -100000;
  int min_gap = 1000000;

  always @(posedge iClk) begin
    #1;
    cyc++;
    if (chk_en) begin
      check("model_btn", 32'(oBtn), 32'(m_btn));
      check("model_busy", 32'(oBusy), 32'(m_busy));
      check("model_sw", 32'(oSwitch), 32'(m_sw));
      check("model_cnt", 32'(oPressCnt), 32'(m_cnt));
    end
    if (oBtn === 1'b1) begin
      pulses++;
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic step(input logic k);
    iKey_n = k;
    @(negedge iClk);
  endtask

  task automatic wait_pulse(input string name);
    int p, n;
    p = pulses; n = 0;
    while (pulses == p && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check({name, "_pulse_seen"}, 32'(pulses != p), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (oBusy !== 1'b0 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check({name, "_idle_seen"}, 32'(oBusy), 32'd0);
  endtask

  int p0;

  initial begin
    repeat (3) @(negedge iClk);
    check("rst_btn", 32'(oBtn), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    iRst_n = 1'b1;
    chk_en = 1'b1;

    // Reset mid-debounce clears everything at once
    iKey_n = 1'b0;
    repeat (5) @(negedge iClk);
    check("t1_pw_busy", 32'(oBusy), 32'd1);
    #2 iRst_n = 1'b0; iKey_n = 1'b1;
    #1;
    check("t1_async_btn", 32'(oBtn), 32'd0);
    check("t1_async_busy", 32'(oBusy), 32'd0);
    check("t1_async_sw", 32'(oSwitch), 32'd0);
    check("t1_async_cnt", 32'(oPressCnt), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (10) @(negedge iClk);
    check("t1_idle_busy", 32'(oBusy), 32'd0);

    // Bounce rejection
    iSwitch = 10'h353;
    p0 = pulses;
    repeat (3) step(1'b0);
    step(1'b1);
    repeat (3) step(1'b0);
    iKey_n = 1'b1;
    repeat (10) @(negedge iClk);
    check("t3_pulses", 32'(pulses - p0), 32'd0);
    check("t3_cnt", 32'(oPressCnt), 32'd0);
    check("t3_busy", 32'(oBusy), 32'd0);

    // Clean press: pulse only after edge 3+D = 7
    p0 = pulses;
    iKey_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge iClk);
      check($sformatf("t2_btn_e%0d", k), 32'(oBtn), 32'(k == 7));
      if (k == 2) check("t2_busy_e2", 32'(oBusy), 32'd0);
      if (k == 3) check("t2_busy_e3", 32'(oBusy), 32'd1);
      if (k == 7) begin
        check("t2_sw", 32'(oSwitch), 32'h353);
        check("t2_cnt", 32'(oPressCnt), 32'd1);
      end
    end
    repeat (41) @(negedge iClk);
    check("t4_hold_pulses", 32'(pulses - p0), 32'd1);

    // Release with a low glitch, then a clean release
    repeat (2) step(1'b1);
    repeat (2) step(1'b0);
    iKey_n = 1'b1;
    repeat (3) @(negedge iClk);
    check("t4_glitch_busy", 32'(oBusy), 32'd1);
    wait_idle("t4");
    check("t4_total_pulses", 32'(pulses - p0), 32'd1);
    check("t4_cnt", 32'(oPressCnt), 32'd1);

    // Switch motion while held is ignored; next press captures it
    iSwitch = 10'h155;
    iKey_n = 1'b0;
    wait_pulse("t5a");
    check("t5_sw_first", 32'(oSwitch), 32'h155);
    repeat (5) @(negedge iClk);
    iSwitch = 10'h0AA;
    repeat (5) @(negedge iClk);
    check("t5_sw_held", 32'(oSwitch), 32'h155);
    iKey_n = 1'b1;
    wait_idle("t5a");
    check("t5_sw_idle", 32'(oSwitch), 32'h155);
    iKey_n = 1'b0;
    wait_pulse("t5b");
    check("t5_sw_second", 32'(oSwitch), 32'h0AA);
    check("t5_cnt", 32'(oPressCnt), 32'd3);
    iKey_n = 1'b1;
    wait_idle("t5b");

    // 256 back-to-back presses wrap the counter
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);
    p0 = pulses;
    last_pulse = -100000;
    min_gap = 1000000;
    for (int i = 0; i < 256; i++) begin
      iSwitch = 10'($urandom);
      iKey_n = 1'b0;
      wait_pulse("t6");
      iKey_n = 1'b1;
      wait_idle("t6");
    end
    check("t6_pulses", 32'(pulses - p0), 32'd256);
    check("t6_cnt_wrap", 32'(oPressCnt), 32'd0);
    check("t6_min_gap", 32'(min_gap >= 2 * D + 3), 32'd1);

    // Key held through a reset release counts as a fresh press
    iKey_n = 1'b0;
    repeat (3) @(negedge iClk);
    #1 iRst_n = 1'b0;
    #2 iRst_n = 1'b1;
    wait_pulse("t7");
    check("t7_cnt", 32'(oPressCnt), 32'd1);
    iKey_n = 1'b1;
    wait_idle("t7");

    // Random key runs, switch noise and occasional asynchronous resets
    for (int r = 0; r < 400; r++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom);
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        iSwitch = 10'($urandom);
        iKey_n = lvl;
        if ($urandom_range(0, 149) == 0) begin
          #1 iRst_n = 1'b0;
          #2 iRst_n = 1'b1;
        end
        @(negedge iClk);
      end
    end
    iKey_n = 1'b1;
    wait_idle("rand_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
